// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage of the 8-bit pipeline.
// Holds the FSM state encoding, the fixed vectors and the instruction-length decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_INT   = 2'd2
  } fetch_state_e;

  localparam logic [7:0] NOP          = 8'h00;
  localparam logic [3:0] OPC_TWO_BYTE = 4'hC;
  localparam logic [7:0] RESET_VEC    = 8'h00;
  localparam logic [7:0] INT_VEC      = 8'h01;

  // LDM/LDD/STD carry an immediate byte in the following memory location.
  function automatic logic is_two_byte(input logic [7:0] instr);
    return instr[7:4] == OPC_TWO_BYTE;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Dual asynchronous-read instruction-memory port used by the fetch stage.
interface fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // No handshake: the memory is always ready and each data port returns
  // M[addr] combinationally in the same cycle the address is presented.
  logic [ADDR_W-1:0] imem_addr0;
  logic [ADDR_W-1:0] imem_addr1;
  logic [DATA_W-1:0] imem_data0;
  logic [DATA_W-1:0] imem_data1;

  modport master (
    output imem_addr0,
    output imem_addr1,
    input  imem_data0,
    input  imem_data1
  );

  modport slave (
    input  imem_addr0,
    input  imem_addr1,
    output imem_data0,
    output imem_data1
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches 1/2-byte instructions, loads the
// reset and interrupt vectors, and honours stall and branch redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              interrupt,
  fetch_if.master           imem,
  output logic [DATA_W-1:0] instr_If,
  output logic [DATA_W-1:0] Imm_If,
  output logic [ADDR_W-1:0] Pc_pluse1_If,
  output logic              interrupt_If,
  output fetch_state_e      state_dbg
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              int_pend_q, int_pend_d;

  logic [ADDR_W-1:0] addr0;
  logic              two_byte;
  logic [ADDR_W-1:0] pc_seq;

  assign two_byte        = is_two_byte(imem.imem_data0);
  assign pc_seq          = two_byte ? pc_q + ADDR_W'(2) : pc_q + ADDR_W'(1);
  assign imem.imem_addr0 = addr0;
  assign imem.imem_addr1 = pc_q + ADDR_W'(1);
  assign state_dbg       = state_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    int_pend_d   = int_pend_q;
    addr0        = pc_q;
    instr_If     = DATA_W'(NOP);
    Imm_If       = '0;
    Pc_pluse1_If = '0;
    interrupt_If = 1'b0;

    // Requests coalesce; an entry in this same cycle clears them below.
    if (interrupt) int_pend_d = 1'b1;

    if (rst) begin
      state_d    = S_RESET;
      pc_d       = '0;
      int_pend_d = 1'b0;
      addr0      = ADDR_W'(RESET_VEC);
    end else begin
      case (state_q)
        S_RESET: begin
          addr0   = ADDR_W'(RESET_VEC);
          pc_d    = ADDR_W'(imem.imem_data0);
          state_d = S_RUN;
        end
        S_INT: begin
          addr0   = ADDR_W'(INT_VEC);
          pc_d    = ADDR_W'(imem.imem_data0);
          state_d = S_RUN;
        end
        default: begin
          if (flush) begin
            pc_d = branch_target;
          end else if (int_pend_q && !stall) begin
            // Entry bubble: current instruction is dropped, pc is the resume address.
            interrupt_If = 1'b1;
            Pc_pluse1_If = pc_q;
            int_pend_d   = 1'b0;
            state_d      = S_INT;
          end else begin
            instr_If     = imem.imem_data0;
            Imm_If       = two_byte ? imem.imem_data1 : '0;
            Pc_pluse1_If = pc_seq;
            if (!stall) pc_d = pc_seq;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    pc_q       <= pc_d;
    int_pend_q <= int_pend_d;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 8-bit pipelined processor; sits directly upstream of the IF/ID pipeline register and drives its IF-side inputs. Owns the PC, reads one- or two-byte instructions from instruction memory, and handles the reset vector (PC ← M[0]) and interrupt vector (PC ← M[1]). Honours the hazard unit's stall and the branch unit's redirect.

## Interface
- ADDR_W, 8, PC / instruction-memory address width
- DATA_W, 8, instruction and immediate width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard stall: hold PC and state; outputs recomputed from held PC
- flush  in  1  taken branch/jump/return: redirect PC to branch_target
- branch_target  in  ADDR_W  redirect address, valid when flush=1
- interrupt  in  1  external interrupt request, single-cycle pulse or level
- imem_addr0  out  ADDR_W  instruction read address (async-read memory port 0)
- imem_data0  in  DATA_W  M[imem_addr0], same cycle
- imem_addr1  out  ADDR_W  immediate read address (port 1)
- imem_data1  in  DATA_W  M[imem_addr1], same cycle
- instr_If  out  DATA_W  instruction to IF/ID
- Imm_If  out  DATA_W  immediate byte to IF/ID; 0 for one-byte instructions
- Pc_pluse1_If  out  ADDR_W  address of next sequential instruction (return address)
- interrupt_If  out  1  marks the interrupt-entry bubble for downstream PC save

## Operation
- States: S_RESET, S_RUN, S_INT.
- rst=1: state←S_RESET, pc←0, int_pend←0. Outputs during and after reset until S_RUN: instr_If=NOP (8'h00), Imm_If=0, Pc_pluse1_If=0, interrupt_If=0.
- S_RESET: imem_addr0=8'h00; pc←imem_data0; state←S_RUN. Ignores stall and flush.
- S_RUN, normal: imem_addr0=pc, imem_addr1=pc+1 (mod 256). instr_If=imem_data0. Two-byte if instr[7:4]==4'hC (LDM/LDD/STD): Imm_If=imem_data1, Pc_pluse1_If=pc+2; else Imm_If=0, Pc_pluse1_If=pc+1. If !stall: pc←Pc_pluse1_If.
- Priority in S_RUN: flush > interrupt entry > sequential.
- flush=1 (overrides stall): pc←branch_target; instr_If=NOP, Imm_If=0, interrupt_If=0; int_pend unchanged.
- Interrupt entry: int_pend=1, !stall, !flush: current instruction not issued; instr_If=NOP, interrupt_If=1, Pc_pluse1_If=pc (resume address); int_pend←0; state←S_INT.
- S_INT: imem_addr0=8'h01; pc←imem_data0; state←S_RUN; outputs NOP, interrupt_If=0. Ignores stall and flush.
- int_pend←1 whenever interrupt=1 (any state, except while rst=1); multiple requests before service coalesce into one. Same-cycle set and clear: set wins only if interrupt is asserted in the S_INT cycle or later.
- PC and +1/+2 arithmetic wrap modulo 2^ADDR_W; at pc=8'hFF, imem_addr1=8'h00.

## Timing
- Fetch is combinational from pc to outputs: zero-cycle latency; IF/ID registers them on the next edge.
- Reset to first real instruction: rst falls, then 1 S_RESET cycle, then the instruction at M[M[0]] appears in the next cycle.
- Interrupt latency: request latched at edge N; entry bubble in cycle N+1 if not stalled; S_INT in N+2; first handler instruction in N+3.
- stall=1 in S_RUN: pc, state, int_pend held (int_pend may still be set); outputs stay stable.
- rst mid-operation: aborts S_INT or a pending interrupt; int_pend is cleared.

## Structure
- Package fetch_pkg: state enum {S_RESET, S_RUN, S_INT}; constants NOP=8'h00, OPC_TWO_BYTE=4'hC, RESET_VEC=8'h00, INT_VEC=8'h01; function is_two_byte(instr).
- Single module, no sub-modules; instruction-length decode is the package function.

## Test plan
- Reset: M[0]=8'h10, M[0x10]=8'h45; pulse rst → one NOP cycle, then instr_If=8'h45, Pc_pluse1_If=8'h11.
- Two-byte: M[0x10]=8'hC1, M[0x11]=8'h7A → instr_If=8'hC1, Imm_If=8'h7A, Pc_pluse1_If=8'h12; next fetch from 0x12.
- Stall/flush: stall 3 cycles at pc=0x20 → outputs constant; flush with target 0x40 during stall → NOP, next fetch from 0x40.
- Interrupt: M[1]=8'h80, pulse interrupt at pc=0x22 → bubble with interrupt_If=1, Pc_pluse1_If=0x22; NOP; then fetch from 0x80.
- Interrupt concurrent with flush to 0x50 → flush taken first; interrupt entry next cycle with Pc_pluse1_If=0x50.
- Wrap: pc=0xFF, one-byte instruction → next pc=0x00; two-byte at 0xFF → Imm from M[0x00], next pc=0x01.
